// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO for the E stage of the MIPS core.
// mult/div results are computed at issue, held in buffers and committed after a fixed latency.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             md_stall,
  output logic             done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] hi_buf_q, hi_buf_d, lo_buf_q, lo_buf_d;
  logic             commit_q, commit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Even opcodes (mult, div) are the signed variants.
  logic                 is_signed;
  logic [2*WIDTH-1:0]   mul_a, mul_b, product;
  logic                 neg_a, neg_b, div_by_zero;
  logic [WIDTH-1:0]     mag_a, mag_b, safe_b, quo_mag, rem_mag, quo, rem;

  assign is_signed = ~md_op[0];

  // Sign/zero extension to 2*WIDTH lets one unsigned multiplier serve both mult and multu.
  assign mul_a   = {{WIDTH{is_signed & src_a[WIDTH-1]}}, src_a};
  assign mul_b   = {{WIDTH{is_signed & src_b[WIDTH-1]}}, src_b};
  assign product = mul_a * mul_b;

  // Divide magnitudes, then restore signs: quotient truncates toward zero and the
  // remainder follows the dividend. most-negative / -1 falls out as most-negative, rem 0.
  assign neg_a       = is_signed & src_a[WIDTH-1];
  assign neg_b       = is_signed & src_b[WIDTH-1];
  assign mag_a       = neg_a ? -src_a : src_a;
  assign mag_b       = neg_b ? -src_b : src_b;
  assign div_by_zero = (src_b == '0);
  assign safe_b      = div_by_zero ? WIDTH'(1) : mag_b;
  assign quo_mag     = mag_a / safe_b;
  assign rem_mag     = mag_a % safe_b;
  assign quo         = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
  assign rem         = neg_a ? -rem_mag : rem_mag;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_buf_d = hi_buf_q;
    lo_buf_d = lo_buf_q;
    commit_d = commit_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    if (abort) begin
      // A flush kills any in-flight op and also blocks a same-edge request.
      if (cnt_q != '0) begin
        cnt_d    = '0;
        hi_buf_d = '0;
        lo_buf_d = '0;
        commit_d = 1'b0;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        done_d = 1'b1;
        if (commit_q) begin
          hi_d = hi_buf_q;
          lo_d = lo_buf_q;
        end
      end
    end else if (start) begin
      case (md_op_e'(md_op))
        OP_MULT, OP_MULTU: begin
          hi_buf_d = product[2*WIDTH-1:WIDTH];
          lo_buf_d = product[WIDTH-1:0];
          commit_d = 1'b1;
          cnt_d    = MULT_LOAD;
        end
        OP_DIV, OP_DIVU: begin
          hi_buf_d = rem;
          lo_buf_d = quo;
          commit_d = ~div_by_zero;
          cnt_d    = DIV_LOAD;
        end
        OP_MTHI: hi_d = src_a;
        OP_MTLO: lo_d = src_a;
        default: ;
      endcase
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      hi_buf_q <= '0;
      lo_buf_q <= '0;
      commit_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_buf_q <= hi_buf_d;
      lo_buf_q <= lo_buf_d;
      commit_q <= commit_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign md_stall = busy_q | (start & ~md_op[2]);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized traffic against
// an arithmetic reference model of HI/LO, busy, done and md_stall.
module tb_md_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [2:0]    md_op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          abort;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          md_stall;
  logic          done;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .abort    (abort),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .md_stall (md_stall),
    .done     (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: architectural HI/LO, cycles left until commit, pending result.
  logic [W-1:0] m_hi, m_lo, m_phi, m_plo;
  logic         m_pcommit, m_done;
  int           m_rem;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void md_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] rhi, output logic [W-1:0] rlo, output logic ok);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ok  = 1'b1;
    rhi = '0;
    rlo = '0;
    case (op)
      3'd0: begin sp = sa * sb; {rhi, rlo} = sp; end
      3'd1: begin up = ua * ub; {rhi, rlo} = up; end
      3'd2: if (b == '0) ok = 1'b0; else begin rlo = 32'(sa / sb); rhi = 32'(sa % sb); end
      3'd3: if (b == '0) ok = 1'b0; else begin rlo = 32'(ua / ub); rhi = 32'(ua % ub); end
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    m_pcommit = 1'b0; m_done = 1'b0; m_rem = 0;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  function automatic void model_edge();
    m_done = 1'b0;
    if (abort) begin
      m_rem = 0;
    end else if (m_rem != 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        if (m_pcommit) begin
          m_hi = m_phi;
          m_lo = m_plo;
        end
      end
    end else if (start) begin
      if (md_op <= 3'd3) begin
        md_ref(md_op, src_a, src_b, m_phi, m_plo, m_pcommit);
        m_rem = (md_op <= 3'd1) ? MC : DC;
      end else if (md_op == 3'd4) begin
        m_hi = src_a;
      end else if (md_op == 3'd5) begin
        m_lo = src_a;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("busy", busy, W'(m_rem != 0));
    check("done", done, W'(m_done));
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ab);
    start = s; md_op = op; src_a = a; src_b = b; abort = ab;
    #1;
    check("md_stall", md_stall, W'((m_rem != 0) | (s & (op <= 3'd3))));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int wait_cycles);
    drive(1'b1, op, a, b, 1'b0);
    tick();
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    repeat (wait_cycles) tick();
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    reset_n = 1'b0;
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    #1;
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_busy", busy, '0);
    check("rst_done", done, '0);
    #5 reset_n = 1'b1;

    // mult -2 * 3
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, MC);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    check("mult_done", done, 32'd1);

    // multu back-to-back in the done cycle
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, DC);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);

    // mthi/mtlo then divu by zero keeps them
    run_op(3'd4, 32'h1234, 32'h0, 0);
    check("mthi_busy", busy, '0);
    run_op(3'd5, 32'h5678, 32'h0, 0);
    check("mtlo_hi", hi, 32'h1234);
    run_op(3'd3, 32'd99, 32'd0, DC);
    check("dz_hi", hi, 32'h1234);
    check("dz_lo", lo, 32'h5678);
    check("dz_done", done, 32'd1);

    // mult 6x7 aborted in its third busy cycle
    run_op(3'd0, 32'd6, 32'd7, 2);
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    tick();
    check("abort_busy", busy, '0);
    check("abort_done", done, '0);
    check("abort_lo", lo, 32'h5678);
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    tick();

    // start issued mid-busy must be ignored
    run_op(3'd0, 32'd6, 32'd7, 1);
    drive(1'b1, 3'd2, 32'd100, 32'd3, 1'b0);
    tick();
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    repeat (3) tick();
    check("ign_lo", lo, 32'd42);
    check("ign_hi", hi, 32'd0);

    // reserved opcodes and start together with abort do nothing
    drive(1'b1, 3'd6, 32'hDEAD, 32'hBEEF, 1'b0); tick();
    drive(1'b1, 3'd7, 32'hDEAD, 32'hBEEF, 1'b0); tick();
    drive(1'b1, 3'd0, 32'd5, 32'd5, 1'b1);       tick();
    check("sa_busy", busy, '0);
    drive(1'b1, 3'd4, 32'hAAAA, 32'd0, 1'b1);    tick();
    check("sa_hi", hi, 32'd0);
    check("rsv_lo", lo, 32'd42);

    // asynchronous reset in the middle of a divide
    run_op(3'd4, 32'hCAFE, 32'h0, 0);
    run_op(3'd2, 32'd1000, 32'd7, 2);
    #1 reset_n = 1'b0;
    #1;
    check("arst_hi", hi, '0);
    check("arst_lo", lo, '0);
    check("arst_busy", busy, '0);
    check("arst_done", done, '0);
    model_reset();
    #1 reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
            ($urandom_range(0, 15) == 0));
      tick();
    end
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    repeat (DC + 1) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
- Extends the single-cycle ALU path with multi-cycle mult/multu/div/divu and single-cycle mthi/mtlo.
- HI and LO are readable at all times for mfhi/mflo.
- Drives busy/stall information to the hazard unit and supports abort on flush.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request valid for md_op this cycle.
- md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op).
- src_a  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data).
- src_b  input  WIDTH  rt operand (divisor / multiplier).
- abort  input  1  kill the in-flight operation (pipeline flush).
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.
- busy  output  1  multi-cycle operation in flight.
- md_stall  output  1  combinational busy | (start & md_op<=3); consumed by the hazard unit.
- done  output  1  one-cycle pulse after HI/LO commit of a mult/div.

Behaviour:
- Reset (reset_n low, asynchronous): hi=0, lo=0, counter=0, busy=0, done=0, result buffers=0. Reset mid-operation discards the operation with no commit.
- States:
  - IDLE: counter==0.
  - BUSY: counter!=0.
  - busy = (counter!=0), registered.
- Accept rule: start is accepted only in IDLE. start while BUSY is ignored entirely; the hazard unit guarantees it via md_stall.
- mult/multu/div/divu accepted at edge t:
  - Full result is computed from src_a/src_b sampled at t into internal buffers hi_buf/lo_buf.
  - counter<=N, where N=MULT_CYCLES or DIV_CYCLES.
  - busy is high for exactly N cycles after edge t.
- BUSY countdown:
  - Each edge decrements counter.
  - At the edge where counter==1: hi<=hi_buf, lo<=lo_buf, counter<=0, done<=1.
  - done is high for the one cycle following that edge. On all other edges done<=0.
  - hi/lo visibly change in the same cycle busy falls.
- Arithmetic:
  - mult: signed WIDTH x WIDTH -> 2*WIDTH product; hi=upper half, lo=lower half.
  - multu: same as mult, unsigned.
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - div, most-negative / -1: lo=most-negative, hi=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (div or divu): full DIV_CYCLES latency, then hi/lo keep their prior values; done still pulses.
- mthi/mtlo accepted in IDLE: hi (resp. lo)<=src_a at that edge. Not busy, no done pulse, the other register unchanged.
- Reserved md_op with start: no effect.
- abort:
  - Sampled each edge. If BUSY: counter<=0, buffers discarded, hi/lo unchanged, done not pulsed. In IDLE it has no effect.
  - abort and start at the same edge: abort wins; the request is not accepted, including mthi/mtlo.
  - abort at the edge where counter==1: the commit is suppressed.
- Back-to-back: a new start is accepted in the cycle busy is low, i.e. the cycle done is high. A new mult/div at that edge reloads the counter with no idle gap.
- hi/lo are pure registers with no bypass of a same-cycle mthi/mtlo; mfhi/mflo forwarding belongs to the pipeline.

Test Plan:
- Reset then mult with src_a=0xFFFFFFFE (-2), src_b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one pulse.
- multu with src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- div:
  - src_a=-7 (0xFFFFFFF9), src_b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - src_a=0x80000000, src_b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu by zero after mthi 0x1234 and mtlo 0x5678 -> busy 10 cycles, hi=0x1234, lo=0x5678, done pulses.
- mult 6x7 started, abort on the 3rd busy cycle -> busy drops the next cycle, hi/lo unchanged, no done. A start ignored mid-busy leaves the result of the first op.
- Deassert reset_n asynchronously mid-div -> hi=lo=0, busy=0 immediately. Also start mult together with abort -> nothing accepted.
